uni_bitstream_counter: RTL

- Downstream stage of the unary MAC array. Converts the unipolar bitstream output `oC` of the 16-lane MAC/orADD stage into a binary count of ones over a fixed window of 2^WIN_LOG2 cycles.
- Ignores a programmable pipeline-fill interval after start, so samples align with valid MAC output.
- Presents each result on a valid/ready handshake, with a sticky overrun flag, to the binary readout logic.

---
 rtl/uni_bitstream_counter.sv | 104 ++++++++++
 1 files changed

// File: rtl/uni_bitstream_counter.sv
// Counts ones in a unary bitstream over a 2^WIN_LOG2-cycle window after a
// programmable fill delay; each result is offered on a valid/ready port.
module uni_bitstream_counter #(
  parameter int WIN_LOG2 = 16,
  parameter int DELAY    = 2,
  parameter int CONT     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  input  logic                in,
  output logic                busy,
  output logic                oValid,
  input  logic                oReady,
  output logic [WIN_LOG2:0]   oCnt,
  output logic                oOverrun
);

  localparam int SKW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [SKW-1:0]      SKIP_LAST = SKW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [WIN_LOG2-1:0] WIN_LAST  = '1;

  typedef enum logic [1:0] {IDLE, SKIP, RUN} state_t;

  state_t              state_q, state_d;
  logic [WIN_LOG2:0]   acc_q, acc_d, cnt_q, cnt_d, sum;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [SKW-1:0]      skip_q, skip_d;
  logic                vld_q, vld_d, ovr_q, ovr_d, load;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    win_d   = win_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    sum     = acc_q + {{WIN_LOG2{1'b0}}, in};
    case (state_q)
      IDLE: if (start) begin
        acc_d   = '0;
        win_d   = '0;
        skip_d  = '0;
        state_d = (DELAY == 0) ? RUN : SKIP;
      end
      SKIP: begin
        skip_d = skip_q + SKW'(1);
        if (skip_q == SKIP_LAST) state_d = RUN;
      end
      RUN: begin
        acc_d = sum;
        win_d = win_q + WIN_LOG2'(1);
        // Last sample of the window: publish acc+in; win wraps to 0 by itself.
        if (win_q == WIN_LAST) begin
          cnt_d = sum;
          load  = 1'b1;
          acc_d = '0;
          if (CONT == 0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d = load | (vld_q & ~oReady);
    ovr_d = ovr_q | (load & vld_q & ~oReady);

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      win_d   = '0;
      skip_d  = '0;
      cnt_d   = '0;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      win_q   <= '0;
      skip_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign oValid   = vld_q;
  assign oCnt     = cnt_q;
  assign oOverrun = ovr_q;

endmodule
